stage_accumulator: RTL and testbench
====================================

# stage_accumulator

Upstream neighbour of the stage-threshold comparator in the Viola–Jones classifier pipeline. It walks the cascade stage by stage and fetches each stage descriptor (feature count, threshold). It accepts one weak-classifier vote (IEEE-754 single) per feature and accumulates the votes with a pipelined FP adder. It then presents the threshold, a single final stage-sum strobe and a last-stage flag to the comparator, and waits there for its next-stage or break decision.

## Interface
- STAGE_CNT, 25: number of cascade stages.
- STAGE_W, 5: stage index width, ≥ clog2(STAGE_CNT).
- FEAT_W, 12: feature-count width.
- ADD_LATENCY, 7: clock latency of the FP adder, ≥ 1.
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  begin a classification from stage 0 (acted on in IDLE only).
- break_i  in  1  comparator abort/idle indication; returns the block to IDLE.
- next_stage_i  in  1  comparator passed a non-last stage; advance.
- stage_idx_o  out  STAGE_W  current stage index.
- stage_desc_req_o  out  1  one-cycle descriptor request for stage_idx_o.
- stage_desc_val_i  in  1  descriptor valid; any latency after the request.
- stage_feat_num_i  in  FEAT_W  features in the stage.
- stage_threshold_i  in  32  stage threshold (float).
- weak_val_i  in  32  weak-classifier vote (float).
- weak_val_val_i  in  1  vote valid.
- weak_ready_o  out  1  vote accepted when valid and ready are both high.
- stage_threshold_o  out  32  held threshold.
- stage_threshold_val_o  out  1  one-cycle threshold strobe.
- stage_sum_o  out  32  accumulated sum, stable from its strobe until the stage is left.
- stage_sum_val_o  out  1  one-cycle final-sum strobe.
- stage_last_o  out  1  stage_idx_o == STAGE_CNT-1.

## Operation
- FSM: IDLE → LOAD → THR → ACCUM ⇄ ADD → REPORT → HOLD.
- IDLE: start_i → clear stage_idx to 0 → LOAD. break_i is ignored in IDLE; the comparator still shows break during the start cycle.
- LOAD: pulse stage_desc_req_o on entry. Wait for stage_desc_val_i, then capture feat_num and threshold, set sum := 32'h0000_0000 and feat_cnt := 0 → THR.
- THR: stage_threshold_val_o = 1 for one cycle. If feat_num == 0 → REPORT, else → ACCUM.
- ACCUM: weak_ready_o = 1. On transfer, register the vote and start add_fp(sum, vote) → ADD.
- ADD: weak_ready_o = 0. Count ADD_LATENCY cycles, then sum := adder result and feat_cnt += 1. If feat_cnt == feat_num → REPORT, else → ACCUM.
- Only one add is in flight at a time. There are no intermediate sum strobes.
- REPORT: stage_sum_val_o = 1 for one cycle → HOLD.
- HOLD: on next_stage_i, stage_idx += 1 → LOAD. On break_i → IDLE.
- If next_stage_i arrives while stage_last_o = 1, ignore it; stage_idx never wraps past STAGE_CNT-1.
- break_i in any non-IDLE state → IDLE next cycle. Drop any in-flight add and any pending descriptor (a late stage_desc_val_i in IDLE is ignored).
- Priority: rst_i > break_i > next_stage_i > start_i.
- Arithmetic: all sums are IEEE single via add_fp. There is no saturation; ±Inf/NaN pass through unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, internal sum 0, stage_idx 0.
- start_i at edge T → stage_desc_req_o high in cycle T+1.
- stage_desc_val_i at edge D → stage_threshold_val_o in D+1 and weak_ready_o in D+2.
- The threshold strobe always precedes the sum strobe by ≥ 1 cycle.
- Last vote accepted at edge A → stage_sum_val_o high in cycle A+ADD_LATENCY+1.
- feat_num == 0: stage_sum_val_o in the cycle after the threshold strobe, with sum = +0.0.
- next_stage_i at edge N → stage_idx_o updated and stage_desc_req_o high in N+1.
- stage_last_o is combinational from the stage_idx register.
- Votes are throttled to at most one per ADD_LATENCY+1 cycles.

## Structure
- Package vj_pkg holds:
  - float_t (logic [31:0]);
  - FP_ZERO = 32'h0;
  - the acc_state_t enum;
  - shared float constants used by benches (FP_ONE = 32'h3F80_0000).
- Sub-module add_fp: a vendor FP adder wrapper with ports clock, aclr, dataa, datab, result and fixed ADD_LATENCY. It matches the style of the comparator wrapper.

## Test plan
- Reset, then start_i with descriptor {feat_num=2, thr=3F80_0000} and votes 3F00_0000, 3FC0_0000 → threshold strobe once, then stage_sum_o = 4000_0000 (2.0) with one stage_sum_val_o pulse at last-accept + ADD_LATENCY+1.
- Three votes 3F80_0000, BE80_0000, BE80_0000 → sum 3F00_0000. weak_ready_o is low during each ADD window, and no intermediate strobes occur.
- feat_num=0 → sum 0000_0000, strobed the cycle after the threshold strobe.
- Stage 0 HOLD, next_stage_i → stage_idx_o=1 and a new desc_req. Run to stage STAGE_CNT-1 → stage_last_o=1, and next_stage_i there leaves the index unchanged.
- break_i mid-ADD and mid-LOAD → IDLE next cycle. A late stage_desc_val_i causes no strobe. A new start_i restarts at stage 0 with sum 0.
- rst_i asserted in ACCUM → all outputs 0 immediately (asynchronous), and the block is in IDLE after release.

Source files
------------

// File: rtl/vj_pkg.sv
// vj_pkg: shared float type, constants and accumulator FSM states for the
// Viola-Jones classifier pipeline.
package vj_pkg;
    typedef logic [31:0] float_t;
    localparam float_t FP_ZERO = 32'h0000_0000;
    localparam float_t FP_ONE  = 32'h3F80_0000;
    localparam int FP_ADD_LATENCY = 7;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_THR, S_ACCUM, S_ADD, S_REPORT, S_HOLD
    } acc_state_t;
endpackage

// File: rtl/stage_accumulator_add_fp.sv
// add_fp: IEEE-754 single-precision adder wrapper, round-to-nearest-even,
// free-running pipeline of LATENCY register stages.
module add_fp
    import vj_pkg::*;
#(
    parameter int LATENCY = FP_ADD_LATENCY
) (
    input  logic   clock,
    input  logic   aclr,
    input  float_t dataa,
    input  float_t datab,
    output float_t result
);
    function automatic float_t fp_add(input float_t a, input float_t b);
        float_t x, y, res;
        logic [7:0] ex, ey;
        logic [9:0] e;
        logic [26:0] mx, my;
        logic [53:0] w;
        logic [27:0] s;
        logic [24:0] r;
        x = (a[30:0] >= b[30:0]) ? a : b;
        y = (a[30:0] >= b[30:0]) ? b : a;
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {|x[30:23], x[22:0], 3'b000};
        // Align the smaller operand, folding shifted-out bits into sticky.
        w = {|y[30:23], y[22:0], 3'b000, 27'd0} >> (ex - ey);
        my = {w[53:28], w[27] | (|w[26:0])};
        s = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], |s[1:0]};
            e = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && e > 10'd1) begin
                s = s << 1;
                e = e - 10'd1;
            end
        end
        r = {1'b0, s[26:3]} + {24'd0, s[2] & (s[3] | s[1] | s[0])};
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'd1;
        end
        res = {x[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
        if (e >= 10'd255) res = {x[31], 8'hFF, 23'd0};
        if (r == 25'd0) res = {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'hFF)
            res = (|x[22:0]) ? (x | 32'h0040_0000) :
                  (y[30:23] == 8'hFF && x[31] != y[31]) ? 32'h7FC0_0000 : x;
        return res;
    endfunction

    float_t pipe_q [LATENCY];
    float_t pipe_d [LATENCY];

    always_comb begin
        pipe_d[0] = fp_add(dataa, datab);
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) pipe_q <= '{default: FP_ZERO};
        else      pipe_q <= pipe_d;
    end

    assign result = pipe_q[LATENCY-1];
endmodule

// File: rtl/stage_accumulator.sv
// stage_accumulator: walks cascade stages, fetches each descriptor, sums the
// weak-classifier votes one add at a time and reports the stage sum.
module stage_accumulator
    import vj_pkg::*;
#(
    parameter int STAGE_CNT   = 25,
    parameter int STAGE_W     = 5,
    parameter int FEAT_W      = 12,
    parameter int ADD_LATENCY = FP_ADD_LATENCY
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               break_i,
    input  logic               next_stage_i,
    output logic [STAGE_W-1:0] stage_idx_o,
    output logic               stage_desc_req_o,
    input  logic               stage_desc_val_i,
    input  logic [FEAT_W-1:0]  stage_feat_num_i,
    input  float_t             stage_threshold_i,
    input  float_t             weak_val_i,
    input  logic               weak_val_val_i,
    output logic               weak_ready_o,
    output float_t             stage_threshold_o,
    output logic               stage_threshold_val_o,
    output float_t             stage_sum_o,
    output logic               stage_sum_val_o,
    output logic               stage_last_o
);
    acc_state_t         state_q, state_d;
    logic [STAGE_W-1:0] idx_q, idx_d;
    logic               req_q, req_d;
    logic [FEAT_W-1:0]  feat_num_q, feat_num_d, feat_cnt_q, feat_cnt_d;
    logic [7:0]         lat_q, lat_d;
    float_t             thr_q, thr_d, sum_q, sum_d, add_res;

    // The vote is captured by the adder's first stage on the accepting edge.
    add_fp #(.LATENCY(ADD_LATENCY)) u_add (
        .clock (clk_i),
        .aclr  (rst_i),
        .dataa (sum_q),
        .datab (weak_val_i),
        .result(add_res)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        req_d      = 1'b0;
        feat_num_d = feat_num_q;
        feat_cnt_d = feat_cnt_q;
        lat_d      = lat_q;
        thr_d      = thr_q;
        sum_d      = sum_q;
        if (break_i && state_q != S_IDLE) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    idx_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_LOAD;
                end
                S_LOAD: if (stage_desc_val_i) begin
                    feat_num_d = stage_feat_num_i;
                    thr_d      = stage_threshold_i;
                    sum_d      = FP_ZERO;
                    feat_cnt_d = '0;
                    state_d    = S_THR;
                end
                S_THR: state_d = (feat_num_q == '0) ? S_REPORT : S_ACCUM;
                S_ACCUM: if (weak_val_val_i) begin
                    lat_d   = 8'd0;
                    state_d = S_ADD;
                end
                S_ADD: if (lat_q == 8'(ADD_LATENCY - 1)) begin
                    sum_d      = add_res;
                    feat_cnt_d = feat_cnt_q + 1'b1;
                    state_d    = (feat_cnt_q + 1'b1 == feat_num_q) ? S_REPORT : S_ACCUM;
                end else lat_d = lat_q + 8'd1;
                S_REPORT: state_d = S_HOLD;
                S_HOLD: if (next_stage_i && !stage_last_o) begin
                    idx_d   = idx_q + 1'b1;
                    req_d   = 1'b1;
                    state_d = S_LOAD;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            req_q      <= 1'b0;
            feat_num_q <= '0;
            feat_cnt_q <= '0;
            lat_q      <= 8'd0;
            thr_q      <= FP_ZERO;
            sum_q      <= FP_ZERO;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            feat_num_q <= feat_num_d;
            feat_cnt_q <= feat_cnt_d;
            lat_q      <= lat_d;
            thr_q      <= thr_d;
            sum_q      <= sum_d;
        end
    end

    assign stage_idx_o           = idx_q;
    assign stage_desc_req_o      = req_q;
    assign weak_ready_o          = state_q == S_ACCUM;
    assign stage_threshold_o     = thr_q;
    assign stage_threshold_val_o = state_q == S_THR;
    assign stage_sum_o           = sum_q;
    assign stage_sum_val_o       = state_q == S_REPORT;
    assign stage_last_o          = idx_q == STAGE_W'(STAGE_CNT - 1);
endmodule

// File: tb/tb_stage_accumulator.sv
// tb_stage_accumulator: directed checks of stage walking, vote accumulation,
// strobe timing, break handling and asynchronous reset.
module tb_stage_accumulator;
    import vj_pkg::*;
    localparam int L = 7;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, brk = 1'b0, next_stage = 1'b0;
    logic desc_val = 1'b0, weak_val_val = 1'b0;
    logic [11:0] feat_num = '0;
    float_t thr_in = '0, weak_val = '0;
    logic [4:0] idx;
    logic desc_req, weak_ready, thr_val, sum_val, last;
    float_t thr_out, sum_out;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    stage_accumulator dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .break_i(brk),
        .next_stage_i(next_stage), .stage_idx_o(idx), .stage_desc_req_o(desc_req),
        .stage_desc_val_i(desc_val), .stage_feat_num_i(feat_num),
        .stage_threshold_i(thr_in), .weak_val_i(weak_val),
        .weak_val_val_i(weak_val_val), .weak_ready_o(weak_ready),
        .stage_threshold_o(thr_out), .stage_threshold_val_o(thr_val),
        .stage_sum_o(sum_out), .stage_sum_val_o(sum_val), .stage_last_o(last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic vote(input float_t v, input bit fin);
        chk("ready_pre", 32'(weak_ready), 1);
        weak_val_val = 1'b1;
        weak_val = v;
        tick();
        weak_val_val = 1'b0;
        chk("ready_drop", 32'(weak_ready), 0);
        repeat (L - 1) begin
            tick();
            chk("add_ready_low", 32'(weak_ready), 0);
            chk("no_mid_strobe", 32'(sum_val), 0);
        end
        tick();
        if (fin) chk("sum_strobe", 32'(sum_val), 1);
        else begin
            chk("ready_back", 32'(weak_ready), 1);
            chk("no_early_strobe", 32'(sum_val), 0);
        end
    endtask

    task automatic load_desc(input logic [11:0] n, input float_t t);
        desc_val = 1'b1;
        feat_num = n;
        thr_in = t;
        tick();
        desc_val = 1'b0;
        chk("thr_strobe", 32'(thr_val), 1);
        chk("thr_value", thr_out, t);
    endtask

    task automatic zero_stage(input int exp_idx);
        next_stage = 1'b1;
        tick();
        next_stage = 1'b0;
        chk("adv_idx", 32'(idx), 32'(exp_idx));
        chk("adv_req", 32'(desc_req), 1);
        chk("adv_last", 32'(last), (exp_idx == 24) ? 1 : 0);
        load_desc(12'd0, 32'h4120_0000);
        chk("zero_no_sum_yet", 32'(sum_val), 0);
        tick();
        chk("zero_sum_strobe", 32'(sum_val), 1);
        chk("zero_sum", sum_out, FP_ZERO);
        chk("zero_thr_off", 32'(thr_val), 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk("rst_idx", 32'(idx), 0);
        chk("rst_req", 32'(desc_req), 0);
        chk("rst_ready", 32'(weak_ready), 0);
        chk("rst_thr_val", 32'(thr_val), 0);
        chk("rst_thr", thr_out, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_sum_val", 32'(sum_val), 0);
        chk("rst_last", 32'(last), 0);
        tick();
        rst = 1'b0;
        tick();
        // Stage 0: 0.5 + 1.5 = 2.0
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_req", 32'(desc_req), 1);
        chk("start_idx", 32'(idx), 0);
        tick();
        chk("req_pulse", 32'(desc_req), 0);
        chk("wait_no_thr", 32'(thr_val), 0);
        load_desc(12'd2, FP_ONE);
        tick();
        chk("thr_once", 32'(thr_val), 0);
        vote(32'h3F00_0000, 1'b0);
        chk("partial_sum", sum_out, 32'h3F00_0000);
        vote(32'h3FC0_0000, 1'b1);
        chk("sum_2p0", sum_out, 32'h4000_0000);
        tick();
        chk("sum_pulse", 32'(sum_val), 0);
        chk("sum_held", sum_out, 32'h4000_0000);
        // Stage 1: 1.0 - 0.25 - 0.25 = 0.5
        next_stage = 1'b1;
        tick();
        next_stage = 1'b0;
        chk("next_idx", 32'(idx), 1);
        chk("next_req", 32'(desc_req), 1);
        load_desc(12'd3, 32'h4040_0000);
        tick();
        vote(FP_ONE, 1'b0);
        vote(32'hBE80_0000, 1'b0);
        vote(32'hBE80_0000, 1'b1);
        chk("sum_0p5", sum_out, 32'h3F00_0000);
        tick();
        for (int k = 2; k <= 24; k++) zero_stage(k);
        chk("last_flag", 32'(last), 1);
        next_stage = 1'b1;
        tick();
        next_stage = 1'b0;
        chk("last_no_wrap", 32'(idx), 24);
        chk("last_no_req", 32'(desc_req), 0);
        // Break from HOLD, then restart while break is still shown
        brk = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        brk = 1'b0;
        chk("restart_req", 32'(desc_req), 1);
        chk("restart_idx", 32'(idx), 0);
        load_desc(12'd2, FP_ONE);
        tick();
        weak_val_val = 1'b1;
        weak_val = FP_ONE;
        tick();
        weak_val_val = 1'b0;
        tick();
        tick();
        brk = 1'b1;
        tick();
        brk = 1'b0;
        chk("brk_add_ready", 32'(weak_ready), 0);
        repeat (L + 2) begin
            tick();
            chk("brk_add_idle_ready", 32'(weak_ready), 0);
            chk("brk_add_no_sum", 32'(sum_val), 0);
        end
        // Break during LOAD; late descriptor must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_req", 32'(desc_req), 1);
        tick();
        brk = 1'b1;
        tick();
        brk = 1'b0;
        desc_val = 1'b1;
        feat_num = 12'd1;
        tick();
        desc_val = 1'b0;
        chk("late_desc_no_thr", 32'(thr_val), 0);
        tick();
        chk("late_desc_no_thr2", 32'(thr_val), 0);
        chk("late_desc_no_ready", 32'(weak_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fresh_idx", 32'(idx), 0);
        chk("fresh_req", 32'(desc_req), 1);
        load_desc(12'd0, 32'h3F00_0000);
        tick();
        chk("fresh_sum_val", 32'(sum_val), 1);
        chk("fresh_sum", sum_out, FP_ZERO);
        tick();
        // Asynchronous reset while waiting in ACCUM at stage 1
        next_stage = 1'b1;
        tick();
        next_stage = 1'b0;
        load_desc(12'd1, 32'h4000_0000);
        tick();
        chk("pre_rst_ready", 32'(weak_ready), 1);
        chk("pre_rst_idx", 32'(idx), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(weak_ready), 0);
        chk("arst_idx", 32'(idx), 0);
        chk("arst_thr", thr_out, 0);
        chk("arst_sum", sum_out, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(weak_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_req", 32'(desc_req), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
